// File: rtl/uart_pi_arb.sv
// -----------------------------------------------------------------------------
// uart_pi_arb
//
// Shares the UART's byte-wide processor interface between two bus masters.
// Ownership is granted round-robin. Each accepted access of the owner is
// registered for one cycle onto the pi_* port. UART read data is routed back
// only to the master that issued the read. A master that does not own the
// port cannot make any access reach the UART.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   An idle-ownership watchdog revokes a grant that is held with no traffic
//   while the other master is waiting. Without the macro, ownership lasts as
//   long as req stays high, and arb_timeout_o is tied low.
//
// Parameters
//   TIMEOUT_W       watchdog counter width (used only with UART_ARB_TIMEOUT_EN)
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   mN_req_i        master N request / hold ownership (level), N = 0,1
//   mN_addr_i       master N register address
//   mN_wr_en_i      master N write strobe, one cycle per access
//   mN_rd_en_i      master N read strobe, one cycle per access
//   mN_wr_data_i    master N write data
//   mN_gnt_o        master N owns the interface (registered)
//   mN_rd_data_o    read data returned to master N
//   mN_rd_valid_o   one-cycle pulse, mN_rd_data_o valid
//   pi_blk_sel_o    UART block select, high with each forwarded strobe
//   pi_addr_o       forwarded address
//   pi_wr_en_o      forwarded write strobe
//   pi_rd_en_o      forwarded read strobe
//   pi_wr_data_o    forwarded write data
//   pi_rd_data_i    UART read data, valid the cycle after pi_rd_en_o
//   arb_timeout_o   one-cycle pulse when the watchdog revokes ownership
// -----------------------------------------------------------------------------
module uart_pi_arb #(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req_i,
  input  logic [3:0] m0_addr_i,
  input  logic       m0_wr_en_i,
  input  logic       m0_rd_en_i,
  input  logic [7:0] m0_wr_data_i,
  output logic       m0_gnt_o,
  output logic [7:0] m0_rd_data_o,
  output logic       m0_rd_valid_o,
  input  logic       m1_req_i,
  input  logic [3:0] m1_addr_i,
  input  logic       m1_wr_en_i,
  input  logic       m1_rd_en_i,
  input  logic [7:0] m1_wr_data_i,
  output logic       m1_gnt_o,
  output logic [7:0] m1_rd_data_o,
  output logic       m1_rd_valid_o,
  output logic       pi_blk_sel_o,
  output logic [3:0] pi_addr_o,
  output logic       pi_wr_en_o,
  output logic       pi_rd_en_o,
  output logic [7:0] pi_wr_data_o,
  input  logic [7:0] pi_rd_data_i,
  output logic       arb_timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_e;

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;   // 1 = m1 was granted last
  logic       m0_gnt_q, m1_gnt_q;

  // Forwarding stage (cycle after acceptance)
  logic       pi_blk_sel_q, pi_wr_en_q, pi_rd_en_q;
  logic [3:0] pi_addr_q;
  logic [7:0] pi_wr_data_q;
  logic       rd_tag_q;                     // issuer of the read in pi stage

  // UART data stage (read data valid on pi_rd_data_i this cycle)
  logic       rd_pend_q, pend_tag_q;

  // Return stage
  logic       m0_rd_valid_q, m1_rd_valid_q;
  logic [7:0] m0_rd_data_q, m1_rd_data_q;

  logic       acc0, acc1, acc_any;
  logic       rd_outstanding;
  logic       req0_ok, req1_ok;             // request eligible for a grant
  logic       revoke;
  logic       arb_timeout_q;

  // An access is taken only from the current owner while it still requests.
  assign acc0    = (state_q == OWN0) & m0_gnt_q & m0_req_i & (m0_wr_en_i | m0_rd_en_i);
  assign acc1    = (state_q == OWN1) & m1_gnt_q & m1_req_i & (m1_wr_en_i | m1_rd_en_i);
  assign acc_any = acc0 | acc1;

  // Reads still waiting for their return pulse: in the pi stage or waiting
  // for UART data. A read in the return stage has already delivered.
  assign rd_outstanding = pi_rd_en_q | rd_pend_q;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 blk0_q, blk1_q;     // revoked master must drop req first
  logic                 owner_idle;

  // Owner holds req with no traffic while the other master waits.
  assign owner_idle = ((state_q == OWN0) & m0_req_i & m1_req_i & ~acc0) |
                      ((state_q == OWN1) & m1_req_i & m0_req_i & ~acc1);
  assign revoke     = owner_idle & (&wd_cnt_q);
  assign wd_cnt_d   = (owner_idle & ~revoke) ? wd_cnt_q + 1'b1 : '0;

  assign req0_ok = m0_req_i & ~blk0_q;
  assign req1_ok = m1_req_i & ~blk1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      blk0_q   <= 1'b0;
      blk1_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (revoke && state_q == OWN0) blk0_q <= 1'b1;
      else if (!m0_req_i)            blk0_q <= 1'b0;
      if (revoke && state_q == OWN1) blk1_q <= 1'b1;
      else if (!m1_req_i)            blk1_q <= 1'b0;
    end
  end
`else
  assign revoke  = 1'b0;
  assign req0_ok = m0_req_i;
  assign req1_ok = m1_req_i;
`endif

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        // On a tie, the master not granted last wins.
        if (req0_ok && (!req1_ok || last_owner_q)) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (req1_ok) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0: if (!m0_req_i || revoke) state_d = rd_outstanding ? DRAIN : IDLE;
      OWN1: if (!m1_req_i || revoke) state_d = rd_outstanding ? DRAIN : IDLE;
      DRAIN: if (!rd_outstanding) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: data registers are reset too; reset must return every output,
      // including rd_data, to zero and discard any in-flight read.
      state_q       <= IDLE;
      last_owner_q  <= 1'b1;
      m0_gnt_q      <= 1'b0;
      m1_gnt_q      <= 1'b0;
      pi_blk_sel_q  <= 1'b0;
      pi_wr_en_q    <= 1'b0;
      pi_rd_en_q    <= 1'b0;
      pi_addr_q     <= '0;
      pi_wr_data_q  <= '0;
      rd_tag_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      pend_tag_q    <= 1'b0;
      m0_rd_valid_q <= 1'b0;
      m1_rd_valid_q <= 1'b0;
      m0_rd_data_q  <= '0;
      m1_rd_data_q  <= '0;
      arb_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      m0_gnt_q     <= (state_d == OWN0);
      m1_gnt_q     <= (state_d == OWN1);

      // Forward the accepted access; idle bus carries zeros.
      pi_blk_sel_q <= acc_any;
      pi_wr_en_q   <= acc1 ? m1_wr_en_i   : (acc0 & m0_wr_en_i);
      pi_rd_en_q   <= acc1 ? m1_rd_en_i   : (acc0 & m0_rd_en_i);
      pi_addr_q    <= acc1 ? m1_addr_i    : (acc0 ? m0_addr_i    : 4'h0);
      pi_wr_data_q <= acc1 ? m1_wr_data_i : (acc0 ? m0_wr_data_i : 8'h00);
      rd_tag_q     <= acc1;

      rd_pend_q    <= pi_rd_en_q;
      pend_tag_q   <= rd_tag_q;

      m0_rd_valid_q <= rd_pend_q & ~pend_tag_q;
      m1_rd_valid_q <= rd_pend_q &  pend_tag_q;
      if (rd_pend_q && !pend_tag_q) m0_rd_data_q <= pi_rd_data_i;
      if (rd_pend_q &&  pend_tag_q) m1_rd_data_q <= pi_rd_data_i;

      arb_timeout_q <= revoke;
    end
  end

  assign m0_gnt_o      = m0_gnt_q;
  assign m1_gnt_o      = m1_gnt_q;
  assign m0_rd_data_o  = m0_rd_data_q;
  assign m1_rd_data_o  = m1_rd_data_q;
  assign m0_rd_valid_o = m0_rd_valid_q;
  assign m1_rd_valid_o = m1_rd_valid_q;
  assign pi_blk_sel_o  = pi_blk_sel_q;
  assign pi_addr_o     = pi_addr_q;
  assign pi_wr_en_o    = pi_wr_en_q;
  assign pi_rd_en_o    = pi_rd_en_q;
  assign pi_wr_data_o  = pi_wr_data_q;
  assign arb_timeout_o = arb_timeout_q;

endmodule
